// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_decoder
// Description : Drains the UART RX FIFO and validates framed register-write
//               commands (SYNC, ADDR, LEN, payload, XOR checksum). A payload
//               reaches the register bus only after its checksum passes.
//               Each frame is answered with a one-byte ACK/NAK pushed into
//               the UART TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_decoder #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       UART_SRC_CK,
  input  logic       UART_RST_N,
  input  logic [7:0] RX_REG,
  input  logic       RX_EMPTY,
  output logic       POP_RX,
  output logic [7:0] TX_REG,
  output logic       PUSH_TX,
  input  logic       TX_FULL,
  output logic       WR_EN,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY,
  output logic [7:0] ERR_CNT
);

  localparam int unsigned IDX_W        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_COMMIT = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t      state;
  logic [7:0]  addr;
  logic [7:0]  len;
  logic [7:0]  xsum;
  logic [7:0]  idx;
  logic [7:0]  reply;
  logic [31:0] idle_cnt;
  logic [7:0]  pay_buf [MAX_LEN];

  logic consuming;
  logic framing;
  logic idle_hit;

  // A byte is consumed in the cycle POP_RX is high; framing states also run the inter-byte timer.
  always_comb begin
    consuming = (state == S_HUNT) || (state == S_ADDR) || (state == S_LEN) ||
                (state == S_DATA) || (state == S_CHK);
    framing   = consuming && (state != S_HUNT);
    idle_hit  = framing && !POP_RX && (idle_cnt == TIMEOUT_LAST);
  end

  // Payload store, written as each data byte is consumed; contents are only meaningful after a full frame.
  always_ff @(posedge UART_SRC_CK) begin
    if (state == S_DATA && POP_RX) begin
      pay_buf[idx[IDX_W-1:0]] <= RX_REG;
    end
  end

  // Frame state machine with all bus, FIFO and status outputs registered.
  always_ff @(posedge UART_SRC_CK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      state    <= S_HUNT;
      POP_RX   <= 1'b0;
      PUSH_TX  <= 1'b0;
      TX_REG   <= 8'h00;
      WR_EN    <= 1'b0;
      WR_ADDR  <= 8'h00;
      WR_DATA  <= 8'h00;
      BUSY     <= 1'b0;
      ERR_CNT  <= 8'h00;
      addr     <= 8'h00;
      len      <= 8'h00;
      xsum     <= 8'h00;
      idx      <= 8'h00;
      reply    <= 8'h00;
      idle_cnt <= 32'd0;
    end else begin
      // Pops are spaced at least one idle cycle apart so the FIFO flags can settle.
      POP_RX  <= !POP_RX && !RX_EMPTY && consuming;
      PUSH_TX <= 1'b0;
      WR_EN   <= 1'b0;

      if (framing) begin
        idle_cnt <= POP_RX ? 32'd0 : idle_cnt + 32'd1;
      end else begin
        idle_cnt <= 32'd0;
      end

      case (state)
        S_HUNT: begin
          if (POP_RX && RX_REG == SYNC_BYTE) begin
            state <= S_ADDR;
            BUSY  <= 1'b1;
          end
        end

        S_ADDR: begin
          if (POP_RX) begin
            addr  <= RX_REG;
            xsum  <= RX_REG;
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (POP_RX) begin
            if (RX_REG == 8'd0 || RX_REG > MAX_LEN_B) begin
              // Unusable length: refuse the frame; trailing bytes fall back into hunting.
              state <= S_RESP;
              reply <= NAK_BYTE;
              if (!TX_FULL) begin
                PUSH_TX <= 1'b1;
                TX_REG  <= NAK_BYTE;
              end
              if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            end else begin
              len   <= RX_REG;
              xsum  <= xsum ^ RX_REG;
              idx   <= 8'd0;
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (POP_RX) begin
            xsum <= xsum ^ RX_REG;
            idx  <= idx + 8'd1;
            if (idx == len - 8'd1) begin
              state <= S_CHK;
            end
          end
        end

        S_CHK: begin
          if (POP_RX) begin
            if (RX_REG == xsum) begin
              // First write issues straight away so it lands the cycle after the checksum byte.
              state   <= S_COMMIT;
              WR_EN   <= 1'b1;
              WR_ADDR <= addr;
              WR_DATA <= pay_buf[0];
              idx     <= 8'd1;
            end else begin
              state <= S_RESP;
              reply <= NAK_BYTE;
              if (!TX_FULL) begin
                PUSH_TX <= 1'b1;
                TX_REG  <= NAK_BYTE;
              end
              if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            end
          end
        end

        S_COMMIT: begin
          if (idx == len) begin
            state <= S_RESP;
            reply <= ACK_BYTE;
            if (!TX_FULL) begin
              PUSH_TX <= 1'b1;
              TX_REG  <= ACK_BYTE;
            end
          end else begin
            WR_EN   <= 1'b1;
            WR_ADDR <= addr + idx;
            WR_DATA <= pay_buf[idx[IDX_W-1:0]];
            idx     <= idx + 8'd1;
          end
        end

        S_RESP: begin
          // Stay here for the push cycle itself so BUSY drops only after the reply is out.
          if (PUSH_TX) begin
            state <= S_HUNT;
            BUSY  <= 1'b0;
          end else if (!TX_FULL) begin
            PUSH_TX <= 1'b1;
            TX_REG  <= reply;
          end
        end

        default: begin
          state <= S_HUNT;
          BUSY  <= 1'b0;
        end
      endcase

      // A stalled sender abandons the frame silently; only the error counter records it.
      if (idle_hit) begin
        state    <= S_HUNT;
        BUSY     <= 1'b0;
        idle_cnt <= 32'd0;
        if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
